// File: rtl/first_nios2_system_tcm_pkg.sv
// ---------------------------------------------------------------------------
// first_nios2_system_tcm_pkg
// Shared definitions for the dual-master tightly coupled data memory:
//   - port identifiers used by the arbiter and the read-response tag pipe
//   - clog2 helper used to size the word address
//   - read-latency legality helper used for the elaboration-time check
// ---------------------------------------------------------------------------
package first_nios2_system_tcm_pkg;

    // Port identifiers; the tag carried with each read names the issuing port.
    localparam logic PORT_S1 = 1'b0;
    localparam logic PORT_S2 = 1'b1;

    // Ceiling log2, never smaller than 1 so a one-word memory still has an address bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 32'd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Only the direct RAM output (1) and one extra output register (2) are built.
    function automatic bit read_latency_legal(input int unsigned latency);
        return (latency == 32'd1) || (latency == 32'd2);
    endfunction

endpackage

// File: rtl/first_nios2_system_tcm_be_ram.sv
// ---------------------------------------------------------------------------
// first_nios2_system_tcm_be_ram
// Inferred single-port RAM with per-byte write enables and a registered read.
// Every enabled cycle the addressed word is read into q (old contents when the
// same cycle writes); enabled writes update only the lanes whose be bit is set.
// Ports:
//   clk    in   clock
//   en     in   access enable (caller guarantees addr < DEPTH when set)
//   we     in   write when enabled, otherwise read
//   addr   in   word address [ADDR_W]
//   be     in   byte-lane write enables [DATA_W/8]
//   wdata  in   write data [DATA_W]
//   q      out  registered read data [DATA_W]
// ---------------------------------------------------------------------------
module first_nios2_system_tcm_be_ram #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter string       INIT_FILE = "UNUSED"
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     q
);

    localparam int unsigned BE_W = DATA_W / 8;

    // Preload image is handed to the FPGA tool through the RAM attribute.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0] mem_array [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_q;

    // RAM array write (byte lanes) and registered read; no reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem_array[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end
            rd_data_q <= mem_array[addr];
        end
    end

    assign q = rd_data_q;

endmodule

// File: rtl/first_nios2_system_tcm_dual_master_ram.sv
// ---------------------------------------------------------------------------
// first_nios2_system_tcm_dual_master_ram
// Tightly coupled data memory shared by two Avalon-MM slave ports
// (s1 = Nios II data master, s2 = DMA/debug master). One access per cycle is
// granted combinationally; the loser sees waitrequest. Reads return after
// READ_LATENCY cycles with readdatavalid on the issuing port only.
// Ports:
//   clk, reset (sync, active high), clken (0 freezes the block)
//   sN_chipselect/read/write/address/byteenable/writedata  request inputs
//   sN_waitrequest     request not accepted this cycle
//   sN_readdata        read data, zero unless sN_readdatavalid
//   sN_readdatavalid   one-cycle read response strobe
// ---------------------------------------------------------------------------
module first_nios2_system_tcm_dual_master_ram
    import first_nios2_system_tcm_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter string       INIT_FILE      = "UNUSED",
    localparam int unsigned ADDR_W        = clog2(DEPTH),
    localparam int unsigned BE_W          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,

    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,

    input  logic              s2_chipselect,
    input  logic              s2_read,
    input  logic              s2_write,
    input  logic [ADDR_W-1:0] s2_address,
    input  logic [BE_W-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0] s2_writedata,
    output logic              s2_waitrequest,
    output logic [DATA_W-1:0] s2_readdata,
    output logic              s2_readdatavalid
);

    // Elaboration-time parameter checks.
    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_read_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if ((DATA_W % 32'd8) != 32'd0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8");
    end

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    // Request / grant
    logic s1_req, s2_req;
    logic grant1, grant2, grant_any;
    logic last_grant_d, last_grant_q;

    // Selected access
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_write;
    logic              in_range;
    logic              rd_issue;
    logic              ram_en;
    logic [DATA_W-1:0] ram_q;

    // Response pipeline: stage 1 aligns with RAM q, stage 2 is the optional output register
    logic              vld1_d, vld1_q;
    logic              tag1_d, tag1_q;
    logic              rng1_d, rng1_q;
    logic [DATA_W-1:0] stage1_data;
    logic              vld2_d, vld2_q;
    logic              tag2_d, tag2_q;
    logic [DATA_W-1:0] data2_d, data2_q;

    logic              out_vld;
    logic              out_tag;
    logic [DATA_W-1:0] out_data;
    logic              rsp_valid;

    // Read together with write counts as a write; chipselect must be set.
    assign s1_req = s1_chipselect & (s1_read | s1_write);
    assign s2_req = s2_chipselect & (s2_read | s2_write);

    // Arbiter: single grant per cycle; ties go to s1 when fixed, else to the port not granted last.
    always_comb begin
        grant1       = 1'b0;
        grant2       = 1'b0;
        last_grant_d = last_grant_q;
        if (clken && !reset) begin
            if (s1_req && s2_req) begin
                if ((FIXED_PRIORITY != 32'd0) || (last_grant_q == PORT_S2)) begin
                    grant1 = 1'b1;
                end else begin
                    grant2 = 1'b1;
                end
            end else if (s1_req) begin
                grant1 = 1'b1;
            end else if (s2_req) begin
                grant2 = 1'b1;
            end else begin
                grant1 = 1'b0;
                grant2 = 1'b0;
            end
        end else begin
            grant1 = 1'b0;
            grant2 = 1'b0;
        end
        if (grant1) begin
            last_grant_d = PORT_S1;
        end else if (grant2) begin
            last_grant_d = PORT_S2;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    assign grant_any      = grant1 | grant2;
    assign s1_waitrequest = s1_req & ~grant1;
    assign s2_waitrequest = s2_req & ~grant2;

    // Steer the granted port's request onto the RAM.
    always_comb begin
        sel_addr  = s1_address;
        sel_be    = s1_byteenable;
        sel_wdata = s1_writedata;
        sel_write = s1_write;
        if (grant2) begin
            sel_addr  = s2_address;
            sel_be    = s2_byteenable;
            sel_wdata = s2_writedata;
            sel_write = s2_write;
        end else begin
            sel_addr  = s1_address;
            sel_be    = s1_byteenable;
            sel_wdata = s1_writedata;
            sel_write = s1_write;
        end
    end

    // Addresses past DEPTH are accepted but never touch the array; reads of them return zero.
    assign in_range = ({1'b0, sel_addr} < DEPTH_LIM);
    assign rd_issue = grant_any & ~sel_write;
    assign ram_en   = grant_any & in_range;

    first_nios2_system_tcm_be_ram #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (sel_write),
        .addr  (sel_addr),
        .be    (sel_be),
        .wdata (sel_wdata),
        .q     (ram_q)
    );

    assign stage1_data = rng1_q ? ram_q : {DATA_W{1'b0}};

    // Next state of the response pipe: cleared by reset, frozen while clken is low.
    always_comb begin
        vld1_d  = vld1_q;
        tag1_d  = tag1_q;
        rng1_d  = rng1_q;
        vld2_d  = vld2_q;
        tag2_d  = tag2_q;
        data2_d = data2_q;
        if (reset) begin
            vld1_d  = 1'b0;
            tag1_d  = PORT_S1;
            rng1_d  = 1'b0;
            vld2_d  = 1'b0;
            tag2_d  = PORT_S1;
            data2_d = {DATA_W{1'b0}};
        end else if (clken) begin
            vld1_d  = rd_issue;
            tag1_d  = grant2;
            rng1_d  = in_range;
            vld2_d  = vld1_q;
            tag2_d  = tag1_q;
            data2_d = stage1_data;
        end else begin
            vld1_d  = vld1_q;
            tag1_d  = tag1_q;
            rng1_d  = rng1_q;
            vld2_d  = vld2_q;
            tag2_d  = tag2_q;
            data2_d = data2_q;
        end
    end

    // Last-grant register; reset to s2 so s1 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= PORT_S2;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Response pipeline registers (reset already folded into the _d terms).
    always_ff @(posedge clk) begin
        vld1_q  <= vld1_d;
        tag1_q  <= tag1_d;
        rng1_q  <= rng1_d;
        vld2_q  <= vld2_d;
        tag2_q  <= tag2_d;
        data2_q <= data2_d;
    end

    // Pick the response stage matching READ_LATENCY.
    always_comb begin
        out_vld  = vld1_q;
        out_tag  = tag1_q;
        out_data = stage1_data;
        if (READ_LATENCY == 32'd2) begin
            out_vld  = vld2_q;
            out_tag  = tag2_q;
            out_data = data2_q;
        end else begin
            out_vld  = vld1_q;
            out_tag  = tag1_q;
            out_data = stage1_data;
        end
    end

    // A held stage is only delivered on a cycle whose edge will also consume it,
    // so each response is seen exactly once; reset suppresses it outright.
    assign rsp_valid        = out_vld & clken & ~reset;
    assign s1_readdatavalid = rsp_valid & (out_tag == PORT_S1);
    assign s2_readdatavalid = rsp_valid & (out_tag == PORT_S2);
    assign s1_readdata      = s1_readdatavalid ? out_data : {DATA_W{1'b0}};
    assign s2_readdata      = s2_readdatavalid ? out_data : {DATA_W{1'b0}};

endmodule
